// File: rtl/board_pkg.sv
// Shared constants and state encoding for the 6x6 tile-matching board controller.
package board_pkg;

  localparam int ROWS      = 6;
  localparam int COLS      = 6;
  localparam int N_CELLS   = 36;
  localparam int MAX_PAIRS = 18;
  localparam int TYPE_W    = 3;
  localparam int IDX_W     = 6;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_PLAY0 = 3'd1,
    ST_PLAY1 = 3'd2,
    ST_CHECK = 3'd3,
    ST_SHOW  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/cursor_mover.sv
// Combinational next-cursor computation for the 6x6 board.
// Priority among simultaneous moves: up > down > left > right.
// Edge behaviour selected by BOARD_CTRL_WRAP_EN: defined wraps within the
// same row/column, undefined leaves the cursor where it is.
module cursor_mover
  import board_pkg::*;
(
  input  logic [IDX_W-1:0] cur_i,
  input  logic             up_i,
  input  logic             down_i,
  input  logic             left_i,
  input  logic             right_i,
  output logic [IDX_W-1:0] nxt_o
);

`ifdef BOARD_CTRL_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  localparam logic [IDX_W-1:0] ROW_STEP  = IDX_W'(COLS);
  localparam logic [IDX_W-1:0] LAST_ROW0 = IDX_W'(N_CELLS - COLS);
  localparam logic [IDX_W-1:0] LAST_COL  = IDX_W'(COLS - 1);

  logic [IDX_W-1:0] col;
  logic             top_row, bot_row, left_col, right_col;

  // Pick the single highest-priority move and apply the edge rule.
  always_comb begin
    col       = cur_i % ROW_STEP;
    top_row   = (cur_i < ROW_STEP);
    bot_row   = (cur_i >= LAST_ROW0);
    left_col  = (col == '0);
    right_col = (col == LAST_COL);
    nxt_o     = cur_i;
    if (up_i) begin
      if (!top_row)  nxt_o = cur_i - ROW_STEP;
      else if (WRAP) nxt_o = cur_i + LAST_ROW0;
    end else if (down_i) begin
      if (!bot_row)  nxt_o = cur_i + ROW_STEP;
      else if (WRAP) nxt_o = cur_i - LAST_ROW0;
    end else if (left_i) begin
      if (!left_col) nxt_o = cur_i - 1'b1;
      else if (WRAP) nxt_o = cur_i + LAST_COL;
    end else if (right_i) begin
      if (!right_col) nxt_o = cur_i + 1'b1;
      else if (WRAP)  nxt_o = cur_i - LAST_COL;
    end
  end

endmodule

// File: rtl/board_ctrl.sv
// Game-board controller for the 6x6 tile-matching display: card-type store,
// cursor, selection pair, cleared map and the play sequencer.
// Optional macro BOARD_CTRL_WRAP_EN: cursor wraps at board edges (see cursor_mover).
module board_ctrl
  import board_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                clk100_in,
  input  logic                rst_n_in,
  input  logic                btn_up_in,
  input  logic                btn_down_in,
  input  logic                btn_left_in,
  input  logic                btn_right_in,
  input  logic                btn_sel_in,
  input  logic                start_in,
  input  logic                load_we_in,
  input  logic [IDX_W-1:0]    load_idx_in,
  input  logic [TYPE_W-1:0]   load_type_in,
  input  logic [IDX_W-1:0]    rd_addr_in,
  output logic [TYPE_W-1:0]   rd_type_out,
  output logic [N_CELLS-1:0]  hidden_bus,
  output logic [N_CELLS-1:0]  blink_bus,
  output logic [N_CELLS-1:0]  sel_bus,
  output logic [IDX_W-1:0]    cursor_out,
  output logic [4:0]          pair_cnt_out,
  output logic                mismatch_out,
  output logic                game_over_out
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]   N_CELLS_IDX = IDX_W'(N_CELLS);
  localparam logic [4:0]         PAIR_LAST   = 5'(MAX_PAIRS - 1);
  localparam logic [N_CELLS-1:0] ONE_CELL    = {{(N_CELLS-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [N_CELLS-1:0] hidden_q, hidden_d;
  logic [N_CELLS-1:0] sel_q, sel_d;
  logic [IDX_W-1:0]   cursor_q, cursor_d;
  logic [IDX_W-1:0]   first_q, first_d;
  logic [IDX_W-1:0]   second_q, second_d;
  logic [4:0]         pair_q, pair_d;
  logic               mis_q, mis_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TYPE_W-1:0]  rd_type_q;
  logic [TYPE_W-1:0]  type_mem_q [N_CELLS];

  logic               playing;
  logic               cur_visible;
  logic               cur_is_first;
  logic               types_eq;
  logic               show_last;
  logic [IDX_W-1:0]   mv_cur;

  // Decode shared by the next-state and datapath logic.
  always_comb begin
    playing      = (state_q == ST_PLAY0) || (state_q == ST_PLAY1);
    cur_visible  = !hidden_q[cursor_q];
    cur_is_first = (cursor_q == first_q);
    types_eq     = (type_mem_q[first_q] == type_mem_q[second_q]);
    show_last    = (cnt_q == CNT_LAST);
  end

  // Moves are only offered when playing and no select pulse claims the cycle.
  cursor_mover u_mover (
    .cur_i   (cursor_q),
    .up_i    (btn_up_in    & playing & ~btn_sel_in),
    .down_i  (btn_down_in  & playing & ~btn_sel_in),
    .left_i  (btn_left_in  & playing & ~btn_sel_in),
    .right_i (btn_right_in & playing & ~btn_sel_in),
    .nxt_o   (mv_cur)
  );

  // State register plus all play-state registers; reset forces the idle board.
  always_ff @(posedge clk100_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_LOAD;
      hidden_q <= '1;
      sel_q    <= '0;
      cursor_q <= '0;
      first_q  <= '0;
      second_q <= '0;
      pair_q   <= '0;
      mis_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hidden_q <= hidden_d;
      sel_q    <= sel_d;
      cursor_q <= cursor_d;
      first_q  <= first_d;
      second_q <= second_d;
      pair_q   <= pair_d;
      mis_q    <= mis_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic of the play sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:  if (start_in) state_d = ST_PLAY0;
      ST_PLAY0: if (btn_sel_in && cur_visible) state_d = ST_PLAY1;
      ST_PLAY1: begin
        if (btn_sel_in) begin
          if (cur_is_first)     state_d = ST_PLAY0;
          else if (cur_visible) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!types_eq)                state_d = ST_SHOW;
        else if (pair_q == PAIR_LAST) state_d = ST_DONE;
        else                          state_d = ST_PLAY0;
      end
      ST_SHOW:  if (show_last) state_d = ST_PLAY0;
      ST_DONE:  if (start_in) state_d = ST_LOAD;
      default:  state_d = ST_LOAD;
    endcase
  end

  // Datapath updates: cursor, selection, cleared map, pair count, hold timer.
  always_comb begin
    hidden_d = hidden_q;
    sel_d    = sel_q;
    cursor_d = cursor_q;
    first_d  = first_q;
    second_d = second_q;
    pair_d   = pair_q;
    mis_d    = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      ST_LOAD: begin
        if (start_in) begin
          hidden_d = '0;
          sel_d    = '0;
          cursor_d = '0;
          pair_d   = '0;
        end
      end
      ST_PLAY0: begin
        if (btn_sel_in) begin
          if (cur_visible) begin
            sel_d[cursor_q] = 1'b1;
            first_d         = cursor_q;
          end
        end else begin
          cursor_d = mv_cur;
        end
      end
      ST_PLAY1: begin
        if (btn_sel_in) begin
          if (cur_is_first) begin
            sel_d[cursor_q] = 1'b0;
          end else if (cur_visible) begin
            sel_d[cursor_q] = 1'b1;
            second_d        = cursor_q;
          end
        end else begin
          cursor_d = mv_cur;
        end
      end
      ST_CHECK: begin
        if (types_eq) begin
          hidden_d = hidden_q | sel_q;
          sel_d    = '0;
          pair_d   = pair_q + 5'd1;
        end else begin
          mis_d = 1'b1;
          cnt_d = '0;
        end
      end
      ST_SHOW: begin
        if (show_last) sel_d = '0;
        else           cnt_d = cnt_q + 1'b1;
      end
      ST_DONE: begin
        if (start_in) hidden_d = '1;
      end
      default: ;
    endcase
  end

  // Card-type store: written only while loading, never reset.
  always_ff @(posedge clk100_in) begin
    if (state_q == ST_LOAD && load_we_in && load_idx_in < N_CELLS_IDX)
      type_mem_q[load_idx_in] <= load_type_in;
  end

  // Registered display read port; addresses past the board read as 0.
  always_ff @(posedge clk100_in) begin
    if (!rst_n_in)                   rd_type_q <= '0;
    else if (rd_addr_in < N_CELLS_IDX) rd_type_q <= type_mem_q[rd_addr_in];
    else                             rd_type_q <= '0;
  end

  // Outputs derived from state and registers.
  always_comb begin
    blink_bus     = '0;
    if (state_q != ST_LOAD && state_q != ST_DONE) blink_bus = ONE_CELL << cursor_q;
    game_over_out = (state_q == ST_DONE);
    hidden_bus    = hidden_q;
    sel_bus       = sel_q;
    cursor_out    = cursor_q;
    pair_cnt_out  = pair_q;
    mismatch_out  = mis_q;
    rd_type_out   = rd_type_q;
  end

endmodule
